key_debounce_multi: RTL and testbench
=====================================

# key_debounce_multi

Parametrised multi-channel push-button conditioner for the board key inputs. It replaces single-key debouncing with a per-channel synchronise/debounce FSM. For each key it produces a debounced level plus one-cycle press, release, long-press and auto-repeat event pulses. It sits between the raw key pads and the control logic that consumes key events.

## Interface
- NUM_KEYS, 4, number of independent key channels (≥1)
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a press or release (≥2)
- LONG_CYC, 50_000_000, hold cycles after accepted press before long_pulse (≥2)
- REPEAT_CYC, 10_000_000, repeat_pulse period after long_pulse; 0 disables repeat (else ≥2)
- ACTIVE_LOW, 1, 1: key pressed when key_in=0; 0: pressed when key_in=1
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_in  in  NUM_KEYS  raw asynchronous key pads
- key_level  out  NUM_KEYS  debounced state, 1 = pressed
- press_pulse  out  NUM_KEYS  one-cycle pulse on accepted press
- release_pulse  out  NUM_KEYS  one-cycle pulse on accepted release
- long_pulse  out  NUM_KEYS  one-cycle pulse after LONG_CYC of hold
- repeat_pulse  out  NUM_KEYS  one-cycle pulse every REPEAT_CYC after long_pulse while held

## Operation
- Each channel is fully independent. There is no shared state between channels.
- Each channel has a 2-FF synchroniser. Its registers reset to the inactive pad level, so release of reset never creates a false edge.
- pressed = synchronised value, inverted when ACTIVE_LOW=1.
- Counters per channel:
  - db_cnt: debounce counter.
  - hold_cnt: hold-time counter.
  - Width of each is $clog2 of the largest parameter, minimum 1.
  - Counters never wrap. Each is cleared on every match.
- Per-channel flag long_done is cleared on entry to IDLE.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE:
  - pressed=1 → PRESS_DB, db_cnt←0.
- PRESS_DB:
  - pressed=0 → IDLE. Glitch; no event.
  - pressed=1 and db_cnt==DEBOUNCE_CYC-1 → HELD. Assert press_pulse, key_level←1, hold_cnt←0, long_done←0.
  - Otherwise db_cnt+1.
- HELD:
  - pressed=0 → RELEASE_DB, db_cnt←0. hold_cnt frozen.
  - Else if !long_done and hold_cnt==LONG_CYC-1: assert long_pulse, long_done←1, hold_cnt←0.
  - Else if long_done, REPEAT_CYC≠0 and hold_cnt==REPEAT_CYC-1: assert repeat_pulse, hold_cnt←0.
  - Else if !long_done, or REPEAT_CYC≠0: hold_cnt+1.
  - When long_done and REPEAT_CYC=0, hold_cnt holds its value.
- RELEASE_DB:
  - pressed=1 → HELD. Bounce; no event. hold_cnt resumes from its frozen value.
  - pressed=0 and db_cnt==DEBOUNCE_CYC-1 → IDLE. Assert release_pulse, key_level←0.
  - Otherwise db_cnt+1.
  - No long_pulse or repeat_pulse is generated in RELEASE_DB.
- Unreachable state codes → IDLE next cycle.
- All outputs are registered. Pulses are exactly one cycle wide.
- At most one pulse type per channel per cycle.

## Timing
- Reset: all outputs 0, all FSMs IDLE, all counters 0.
- Press latency, with key_in changing before edge 0 and then stable:
  - pressed visible after edge 2.
  - PRESS_DB entered at edge 3.
  - press_pulse and key_level=1 from edge DEBOUNCE_CYC+3.
- Release latency: symmetric. release_pulse and key_level=0 from edge DEBOUNCE_CYC+3 after the stable release.
- Long press: if HELD is entered at edge P, long_pulse occurs at edge P+LONG_CYC.
- Auto-repeat: repeat_pulse occurs at P+LONG_CYC+k·REPEAT_CYC, k≥1, provided no bounce excursion.
- A RELEASE_DB excursion of m cycles delays subsequent long/repeat pulses by m+1 cycles (frozen counter plus the return transition).
- Reset asserted mid-operation: outputs clear immediately (asynchronous).
  - A key held through reset release is treated as a new press.
  - press_pulse follows DEBOUNCE_CYC+3 edges after reset deassertion.
- Simultaneous events on different channels produce simultaneous independent pulses.

## Test plan
Bench configuration: NUM_KEYS=2, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, ACTIVE_LOW=1.
- Clean press: key_in[0] 1→0 before edge 0, held → press_pulse[0]=1 for the single cycle after edge 7. key_level[0]=1 from edge 7. No events on channel 1.
- Press glitch: key_in[0]=0 for 3 cycles, then 1 → no pulses at all. key_level[0] stays 0.
- Long hold: press as above, held through edge 50 → long_pulse[0] at edge 27. repeat_pulse[0] at edges 35 and 43 only.
- Release bounce: while HELD, key_in[0] goes high for 2 cycles, then low → no release_pulse, key_level stays 1. A later stable high before edge R → release_pulse[0] at edge R+7, key_level[0]=0.
- REPEAT_CYC=0 variant: 60-cycle hold → exactly one long_pulse, zero repeat_pulse.
- Reset mid-hold: rst_n low while key_in[1]=0 → all outputs 0 at once. After deassertion, press_pulse[1] fires 7 edges later.

Source files
------------

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: per-key synchroniser, debounce FSM,
// debounced level and one-cycle press/release/long/repeat event pulses.
module key_debounce_multi #(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int unsigned MAX_DL = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int unsigned MAX_P  = (MAX_DL > REPEAT_CYC) ? MAX_DL : REPEAT_CYC;
  localparam int unsigned CW     = (MAX_P < 2) ? 1 : $clog2(MAX_P);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST  = (REPEAT_CYC == 0) ? '0 : CW'(REPEAT_CYC - 1);
  localparam logic          REPEAT_EN = (REPEAT_CYC != 0);
  localparam logic          IDLE_PAD  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_RELEASE_DB
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic          sync1, sync2, pressed;
    state_t        state;
    logic [CW-1:0] db_cnt, hold_cnt;
    logic          long_done;
    logic          level, pp, rlp, lp, rp;

    // Synchroniser resets to the idle pad level so reset release never looks
    // like a press; pressed is registered once more, giving a 3-edge input lag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1     <= IDLE_PAD;
        sync2     <= IDLE_PAD;
        pressed   <= 1'b0;
        state     <= S_IDLE;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        long_done <= 1'b0;
        level     <= 1'b0;
        pp        <= 1'b0;
        rlp       <= 1'b0;
        lp        <= 1'b0;
        rp        <= 1'b0;
      end else begin
        sync1   <= key_in[i];
        sync2   <= sync1;
        pressed <= sync2 ^ IDLE_PAD;
        pp      <= 1'b0;
        rlp     <= 1'b0;
        lp      <= 1'b0;
        rp      <= 1'b0;
        case (state)
          S_IDLE: begin
            if (pressed) begin
              state  <= S_PRESS_DB;
              db_cnt <= '0;
            end
          end
          S_PRESS_DB: begin
            if (!pressed) begin
              state     <= S_IDLE;
              long_done <= 1'b0;
            end else if (db_cnt == DB_LAST) begin
              state     <= S_HELD;
              pp        <= 1'b1;
              level     <= 1'b1;
              hold_cnt  <= '0;
              long_done <= 1'b0;
            end else begin
              db_cnt <= db_cnt + CW'(1);
            end
          end
          S_HELD: begin
            // hold_cnt is left untouched on exit so a bounce resumes the count
            if (!pressed) begin
              state  <= S_RELEASE_DB;
              db_cnt <= '0;
            end else if (!long_done && hold_cnt == LONG_LAST) begin
              lp        <= 1'b1;
              long_done <= 1'b1;
              hold_cnt  <= '0;
            end else if (long_done && REPEAT_EN && hold_cnt == RPT_LAST) begin
              rp       <= 1'b1;
              hold_cnt <= '0;
            end else if (!long_done || REPEAT_EN) begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
          S_RELEASE_DB: begin
            if (pressed) begin
              state <= S_HELD;
            end else if (db_cnt == DB_LAST) begin
              state     <= S_IDLE;
              rlp       <= 1'b1;
              level     <= 1'b0;
              long_done <= 1'b0;
            end else begin
              db_cnt <= db_cnt + CW'(1);
            end
          end
          default: begin
            state     <= S_IDLE;
            long_done <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[i]     = level;
    assign press_pulse[i]   = pp;
    assign release_pulse[i] = rlp;
    assign long_pulse[i]    = lp;
    assign repeat_pulse[i]  = rp;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: press, glitch, long/repeat, bounce,
// release, repeat-disabled variant and asynchronous reset mid-hold.
module tb_key_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_in;

  logic [1:0] key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [1:0] z_key_level, z_press_pulse, z_release_pulse, z_long_pulse, z_repeat_pulse;

  int n_checks = 0;
  int n_errors = 0;

  key_debounce_multi #(
    .NUM_KEYS(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  key_debounce_multi #(
    .NUM_KEYS(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(0), .ACTIVE_LOW(1'b1)
  ) dut_norpt (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(z_key_level), .press_pulse(z_press_pulse), .release_pulse(z_release_pulse),
    .long_pulse(z_long_pulse), .repeat_pulse(z_repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int z_long_cnt;
  int z_rpt_cnt;

  initial begin
    rst_n  = 1'b0;
    key_in = 2'b11;
    repeat (3) tick();
    check("reset_level",   {30'd0, key_level},     32'd0);
    check("reset_press",   {30'd0, press_pulse},   32'd0);
    check("reset_release", {30'd0, release_pulse}, 32'd0);
    check("reset_long",    {30'd0, long_pulse},    32'd0);
    check("reset_repeat",  {30'd0, repeat_pulse},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // Glitch: 3 cycles low is one short of the 4-cycle debounce.
    key_in[0] = 1'b0;
    repeat (3) tick();
    key_in[0] = 1'b1;
    for (int e = 0; e < 15; e++) begin
      tick();
      check("glitch_press", {31'd0, press_pulse[0]}, 32'd0);
      check("glitch_level", {31'd0, key_level[0]},   32'd0);
    end

    // Clean press held to edge 60: press@7, long@27, repeat@35,43,51,59.
    z_long_cnt = 0;
    z_rpt_cnt  = 0;
    key_in[0] = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      tick();
      check("press_pulse", {31'd0, press_pulse[0]}, {31'd0, e == 7});
      check("press_level", {31'd0, key_level[0]},   {31'd0, e >= 7});
      check("long_pulse",  {31'd0, long_pulse[0]},  {31'd0, e == 27});
      check("repeat_pulse", {31'd0, repeat_pulse[0]},
            {31'd0, (e > 27) && ((e - 27) % 8 == 0)});
      check("ch1_quiet", {28'd0, key_level[1], press_pulse[1], long_pulse[1], repeat_pulse[1]}, 32'd0);
      if (z_long_pulse[0]) z_long_cnt++;
      if (z_repeat_pulse[0]) z_rpt_cnt++;
      if (e == 27) check("norpt_long_at_27", {31'd0, z_long_pulse[0]}, 32'd1);
    end
    check("norpt_long_count",   z_long_cnt, 32'd1);
    check("norpt_repeat_count", z_rpt_cnt,  32'd0);

    // Release bounce: 2 cycles high then low again, must not release.
    key_in[0] = 1'b1;
    repeat (2) tick();
    key_in[0] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      check("bounce_release", {31'd0, release_pulse[0]}, 32'd0);
      check("bounce_level",   {31'd0, key_level[0]},     32'd1);
    end

    // Stable release: release_pulse at R+7.
    key_in[0] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      check("release_pulse", {31'd0, release_pulse[0]}, {31'd0, e == 7});
      check("release_level", {31'd0, key_level[0]},     {31'd0, e < 7});
    end

    // Simultaneous presses on both channels pulse together.
    key_in = 2'b00;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("dual_press", {30'd0, press_pulse}, (e == 7) ? 32'd3 : 32'd0);
    end
    key_in[0] = 1'b1;
    repeat (5) tick();

    // Asynchronous reset mid-hold on channel 1, then re-press from reset.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_level",   {30'd0, key_level},     32'd0);
    check("async_pulses",  {22'd0, press_pulse, release_pulse, long_pulse, repeat_pulse, 2'b00}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 11; e++) begin
      tick();
      check("rst_press1", {31'd0, press_pulse[1]}, {31'd0, e == 7});
      check("rst_level1", {31'd0, key_level[1]},   {31'd0, e >= 7});
      check("rst_ch0",    {31'd0, press_pulse[0]}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
